irq_pending_latch: RTL

Interrupt capture stage placed directly upstream of the 8:3 priority encoder. Detects rising edges on eight request lines, holds them as sticky pending bits, applies a per-line enable mask and drives the masked pending vector into the encoder's 8-bit input. The encoder's 3-bit result returns to this block as the acknowledge index, which clears the serviced bit.

---
 rtl/irq_pending_latch_pkg.sv | 24 ++
 rtl/irq_pending_latch_if.sv | 37 +++
 rtl/irq_pending_latch_edge_detect.sv | 33 +++
 rtl/irq_pending_latch.sv | 75 +++++++
 4 files changed

// File: rtl/irq_pending_latch_pkg.sv
// Shared widths, reset constants and the ack-index to clear-vector helper
// used by the pending latch, its edge detector and its interface.
package irq_pkg;

    localparam int IRQ_WIDTH = 8;
    localparam int IRQ_IDX_W = 3;

    localparam logic [IRQ_WIDTH-1:0] IRQ_REQ_RESET = 8'hFF;
    localparam logic [IRQ_WIDTH-1:0] IRQ_ZERO      = '0;

    // One-hot clear vector for the acknowledged line; all zeros when not acking.
    function automatic logic [IRQ_WIDTH-1:0] idx_to_onehot(
        input logic [IRQ_IDX_W-1:0] idx,
        input logic                 en
    );
        logic [IRQ_WIDTH-1:0] oh;
        oh = '0;
        for (int i = 0; i < IRQ_WIDTH; i++) begin
            oh[i] = en && (idx == i[IRQ_IDX_W-1:0]);
        end
        return oh;
    endfunction

endpackage

// File: rtl/irq_pending_latch_if.sv
// Request/mask/acknowledge bundle between the interrupt sources, the pending
// latch (slave) and the downstream encoder/service logic (master).
interface irq_pending_latch_if;
    import irq_pkg::*;

    logic [IRQ_WIDTH-1:0] req;
    logic [IRQ_WIDTH-1:0] mask;
    logic                 ack;
    logic [IRQ_IDX_W-1:0] ack_idx;
    logic                 ovf_clr;
    logic [IRQ_WIDTH-1:0] pend_out;
    logic                 irq;
    logic [IRQ_WIDTH-1:0] ovf;

    modport master (
        output req,
        output mask,
        output ack,
        output ack_idx,
        output ovf_clr,
        input  pend_out,
        input  irq,
        input  ovf
    );

    modport slave (
        input  req,
        input  mask,
        input  ack,
        input  ack_idx,
        input  ovf_clr,
        output pend_out,
        output irq,
        output ovf
    );

endinterface

// File: rtl/irq_pending_latch_edge_detect.sv
// Rising-edge detector: registers the previous request vector and flags
// lines that are high now but were low on the previous sample.
module irq_edge_detect #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] req_q;
    logic [WIDTH-1:0] req_d;

    assign req_d = req_i;

    // Resetting the history to ones keeps lines already high at release quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= RESET_VAL;
        end else begin
            req_q <= req_d;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rise
            assign rise_o[gi] = req_i[gi] & ~req_q[gi];
        end
    endgenerate

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky interrupt pending latch feeding the 8:3 priority encoder.
// Optional sticky overflow flags are built only when IRQ_LATCH_OVF_EN is defined.
module irq_pending_latch
    import irq_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    irq_pending_latch_if.slave        irq_if
);

    logic [IRQ_WIDTH-1:0] rise_w;
    logic [IRQ_WIDTH-1:0] clr_w;
    logic [IRQ_WIDTH-1:0] pend_q;
    logic [IRQ_WIDTH-1:0] pend_d;

    irq_edge_detect #(
        .WIDTH     (IRQ_WIDTH),
        .RESET_VAL (IRQ_REQ_RESET)
    ) u_edge (
        .clk    (clk),
        .rst    (rst),
        .req_i  (irq_if.req),
        .rise_o (rise_w)
    );

    assign clr_w = idx_to_onehot(irq_if.ack_idx, irq_if.ack);

    // Set dominates clear so an event arriving with its own ack is not lost.
    generate
        for (genvar gi = 0; gi < IRQ_WIDTH; gi++) begin : g_pend
            assign pend_d[gi] = (pend_q[gi] & ~clr_w[gi]) | rise_w[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= IRQ_ZERO;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign irq_if.pend_out = pend_q & irq_if.mask;
    assign irq_if.irq      = |(pend_q & irq_if.mask);

`ifdef IRQ_LATCH_OVF_EN
    logic [IRQ_WIDTH-1:0] ovf_q;
    logic [IRQ_WIDTH-1:0] ovf_d;
    logic [IRQ_WIDTH-1:0] ovf_set;

    // An event on a line still pending (and not being serviced) is a lost event.
    generate
        for (genvar gi = 0; gi < IRQ_WIDTH; gi++) begin : g_ovf
            assign ovf_set[gi] = rise_w[gi] & pend_q[gi] & ~clr_w[gi];
            assign ovf_d[gi]   = (ovf_q[gi] & ~irq_if.ovf_clr) | ovf_set[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= IRQ_ZERO;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign irq_if.ovf = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = irq_if.ovf_clr;
    assign irq_if.ovf     = IRQ_ZERO;
`endif

endmodule
